// File: rtl/cpu_store_buffer.sv
// Store buffer: in-order FIFO of pending {tag, data} stores between the LSU and the
// data cache, with associative store-to-load forwarding (newest matching entry wins).
module cpu_store_buffer #(
    parameter int SIZE       = 3,
    parameter int TAG_WIDTH  = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  operation,
    input  logic                  pop,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [TAG_WIDTH-1:0]  tag_pop,
    output logic [DATA_WIDTH-1:0] data_pop,
    output logic                  empty,
    output logic                  full,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] data_response
);

    localparam logic OP_REQUEST = 1'b0;
    localparam logic OP_PUSH    = 1'b1;
    localparam int   CW         = $clog2(SIZE + 1);
    localparam int   PW         = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [TAG_WIDTH-1:0]  tags  [SIZE];
    logic [DATA_WIDTH-1:0] datas [SIZE];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    logic                  do_push;
    logic                  do_pop;
    logic                  match_any;
    logic [DATA_WIDTH-1:0] match_data;

    // Physical slot that lies 'offset' entries after 'base', wrapping at SIZE.
    function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= SIZE) s = s - SIZE;
        return s[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(SIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(SIZE));
    assign tag_pop  = tags[head];
    assign data_pop = datas[head];

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = (operation == OP_PUSH) && (!full || pop);

    // Walk entries oldest to newest so the last match seen is the newest one.
    always_comb begin
        match_any  = 1'b0;
        match_data = '0;
        for (int i = 0; i < SIZE; i++) begin
            if ((i < int'(count)) && (tags[slot(head, i)] == tag_in)) begin
                match_any  = 1'b1;
                match_data = datas[slot(head, i)];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < SIZE; i++) begin
                tags[i]  <= '0;
                datas[i] <= '0;
            end
        end else begin
            if (do_push) begin
                tags[tail]  <= tag_in;
                datas[tail] <= data_in;
                tail        <= next_ptr(tail);
            end
            if (do_pop) begin
                head <= next_ptr(head);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Lookup result is held until the next REQUEST overwrites it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit           <= 1'b0;
            data_response <= '0;
        end else if (operation == OP_REQUEST) begin
            hit           <= match_any;
            data_response <= match_data;
        end
    end

endmodule

// File: tb/tb_cpu_store_buffer.sv
// Self-checking bench for cpu_store_buffer: a queue model of the buffer plus a
// scoreboard of expected lookup responses, checked scenario by scenario.
module tb_cpu_store_buffer;

    localparam int SIZE = 3;
    localparam int TW   = 16;
    localparam int DW   = 16;
    localparam logic REQ  = 1'b0;
    localparam logic PUSH = 1'b1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          operation = REQ;
    logic          pop = 1'b0;
    logic [TW-1:0] tag_in = '0;
    logic [DW-1:0] data_in = '0;
    logic [TW-1:0] tag_pop;
    logic [DW-1:0] data_pop;
    logic          empty;
    logic          full;
    logic          hit;
    logic [DW-1:0] data_response;

    int errors = 0;
    int checks = 0;

    logic [TW-1:0] model_tag [$];
    logic [DW-1:0] model_data [$];
    logic          sb_hit [$];
    logic [DW-1:0] sb_data [$];
    logic          exp_hit;
    logic [DW-1:0] exp_data;

    cpu_store_buffer #(.SIZE(SIZE), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .operation(operation), .pop(pop),
        .tag_in(tag_in), .data_in(data_in), .tag_pop(tag_pop), .data_pop(data_pop),
        .empty(empty), .full(full), .hit(hit), .data_response(data_response)
    );

    always #5 clock = ~clock;

    // Drive one cycle, update the model, queue the expected lookup result, then
    // step to just after the rising edge.
    task automatic drive_cycle(input logic op, input logic p, input logic [TW-1:0] t,
                               input logic [DW-1:0] d);
        logic h;
        logic [DW-1:0] v;
        bit pop_eff;
        bit push_eff;
        operation = op;
        pop       = p;
        tag_in    = t;
        data_in   = d;
        if (op == REQ) begin
            h = 1'b0;
            v = '0;
            for (int i = model_tag.size() - 1; i >= 0; i--) begin
                if (!h && model_tag[i] == t) begin
                    h = 1'b1;
                    v = model_data[i];
                end
            end
            sb_hit.push_back(h);
            sb_data.push_back(v);
        end
        pop_eff  = p && (model_tag.size() > 0);
        push_eff = (op == PUSH) && ((model_tag.size() < SIZE) || p);
        if (pop_eff) begin
            void'(model_tag.pop_front());
            void'(model_data.pop_front());
        end
        if (push_eff) begin
            model_tag.push_back(t);
            model_data.push_back(d);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic take_expected();
        if (sb_hit.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_underflow: got empty queue, required one entry");
            exp_hit  = 1'b0;
            exp_data = '0;
        end else begin
            exp_hit  = sb_hit.pop_front();
            exp_data = sb_data.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b required 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b required 0", full); end
        checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %b required 0", hit); end
        checks++; if (data_response !== '0) begin errors++; $display("[TB] FAIL reset_resp: got %h required 0", data_response); end
        checks++; if (tag_pop !== '0 || data_pop !== '0) begin errors++; $display("[TB] FAIL reset_head: got %h/%h required 0/0", tag_pop, data_pop); end
        @(negedge clock);
        reset = 1'b1;
        drive_cycle(REQ, 1'b0, 16'h0000, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL reset_request: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got empty=%b full=%b required 1/0", empty, full); end
    endtask

    task automatic test_push_single();
        drive_cycle(PUSH, 1'b0, 16'h0010, 16'h000A);
        checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("[TB] FAIL push1_flags: got empty=%b full=%b required 0/0", empty, full); end
        checks++; if (tag_pop !== model_tag[0] || data_pop !== model_data[0]) begin errors++; $display("[TB] FAIL push1_head: got %h/%h required %h/%h", tag_pop, data_pop, model_tag[0], model_data[0]); end
    endtask

    task automatic test_request_pop();
        drive_cycle(REQ, 1'b1, 16'h0010, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL fwd_pop: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fwd_pop_empty: got %b required 1", empty); end
        drive_cycle(PUSH, 1'b0, 16'h0030, 16'h0001);
        checks++; if (hit !== 1'b1 || data_response !== 16'h000A) begin errors++; $display("[TB] FAIL hold_push: got %b/%h required 1/000a", hit, data_response); end
        drive_cycle(PUSH, 1'b1, 16'h0031, 16'h0002);
        checks++; if (hit !== 1'b1 || data_response !== 16'h000A) begin errors++; $display("[TB] FAIL hold_pushpop: got %b/%h required 1/000a", hit, data_response); end
        checks++; if (tag_pop !== 16'h0031 || data_pop !== 16'h0002) begin errors++; $display("[TB] FAIL hold_head: got %h/%h required 0031/0002", tag_pop, data_pop); end
        drive_cycle(REQ, 1'b1, 16'h0031, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data || empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_fwd: got %b/%h empty=%b required %b/%h empty=1", hit, data_response, empty, exp_hit, exp_data); end
    endtask

    task automatic test_newest_wins();
        logic [DW-1:0] vals [3] = '{16'h000A, 16'h000B, 16'h000C};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(PUSH, 1'b0, 16'h0010, vals[i]);
            checks++; if (full !== (i == 2)) begin errors++; $display("[TB] FAIL fill_full_%0d: got %b required %b", i, full, (i == 2)); end
        end
        drive_cycle(REQ, 1'b0, 16'h0010, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL newest_wins: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
    endtask

    task automatic test_full();
        drive_cycle(PUSH, 1'b0, 16'h0020, 16'h000D);
        checks++; if (full !== 1'b1 || tag_pop !== 16'h0010 || data_pop !== 16'h000A) begin errors++; $display("[TB] FAIL full_drop: got full=%b %h/%h required 1 0010/000a", full, tag_pop, data_pop); end
        drive_cycle(REQ, 1'b0, 16'h0020, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL full_drop_lookup: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
        drive_cycle(PUSH, 1'b1, 16'h0020, 16'h000D);
        checks++; if (full !== 1'b1 || tag_pop !== 16'h0010 || data_pop !== 16'h000B) begin errors++; $display("[TB] FAIL full_pushpop: got full=%b %h/%h required 1 0010/000b", full, tag_pop, data_pop); end
        drive_cycle(REQ, 1'b0, 16'h0020, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL full_append_lookup: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
    endtask

    task automatic test_miss_drain();
        drive_cycle(REQ, 1'b0, 16'h0099, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL miss: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(REQ, 1'b1, 16'h0099, 16'h0000);
            take_expected();
            checks++; if (empty !== (model_tag.size() == 0)) begin errors++; $display("[TB] FAIL drain_empty_%0d: got %b required %b", i, empty, (model_tag.size() == 0)); end
            if (model_tag.size() > 0) begin
                checks++; if (data_pop !== model_data[0]) begin errors++; $display("[TB] FAIL drain_head_%0d: got %h required %h", i, data_pop, model_data[0]); end
            end
        end
        drive_cycle(REQ, 1'b1, 16'h0099, 16'h0000);
        take_expected();
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL extra_pop: got empty=%b full=%b required 1/0", empty, full); end
        drive_cycle(PUSH, 1'b1, 16'h0040, 16'h0005);
        checks++; if (empty !== 1'b0 || tag_pop !== 16'h0040 || data_pop !== 16'h0005) begin errors++; $display("[TB] FAIL empty_pushpop: got empty=%b %h/%h required 0 0040/0005", empty, tag_pop, data_pop); end
    endtask

    task automatic test_back_to_back();
        drive_cycle(PUSH, 1'b0, 16'h0041, 16'h0006);
        drive_cycle(PUSH, 1'b1, 16'h0042, 16'h0007);
        checks++; if (empty !== 1'b0 || full !== 1'b0 || tag_pop !== 16'h0041) begin errors++; $display("[TB] FAIL b2b_head: got empty=%b full=%b tag=%h required 0/0 0041", empty, full, tag_pop); end
        drive_cycle(PUSH, 1'b0, 16'h0043, 16'h0008);
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL b2b_count: got full=%b required 1", full); end
        drive_cycle(REQ, 1'b0, 16'h0042, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL b2b_lookup: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
        drive_cycle(REQ, 1'b0, 16'h0044, 16'h0000);
        drive_cycle(PUSH, 1'b1, 16'h0044, 16'h0009);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL same_cycle_push_invisible: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
        drive_cycle(REQ, 1'b0, 16'h0044, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL wrapped_lookup: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got empty=%b full=%b required 1/0", empty, full); end
        checks++; if (hit !== 1'b0 || data_response !== '0) begin errors++; $display("[TB] FAIL midreset_resp: got %b/%h required 0/0", hit, data_response); end
        checks++; if (tag_pop !== '0 || data_pop !== '0) begin errors++; $display("[TB] FAIL midreset_head: got %h/%h required 0/0", tag_pop, data_pop); end
        model_tag.delete();
        model_data.delete();
        sb_hit.delete();
        sb_data.delete();
        @(negedge clock);
        reset = 1'b1;
        drive_cycle(REQ, 1'b0, 16'h0042, 16'h0000);
        take_expected();
        checks++; if (hit !== exp_hit || data_response !== exp_data) begin errors++; $display("[TB] FAIL midreset_lookup: got %b/%h required %b/%h", hit, data_response, exp_hit, exp_data); end
    endtask

    initial begin
        test_reset();
        test_push_single();
        test_request_pop();
        test_newest_wins();
        test_full();
        test_miss_drain();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
